sdram_image_reader: RTL and testbench
=====================================

SDRAM_IMAGE_READER -- requirements
Module: sdram_image_reader

Interface
REQ-001 Parameter H_PIXELS, default 160: pixels per image line.
REQ-002 Parameter V_LINES, default 120: lines per image.
REQ-003 Parameter BASE_ADDR, default 23'h0: SDRAM word address of pixel (0,0).
REQ-004 Parameter FIFO_DEPTH, default 8 (power of 2): pixel buffer entries.
REQ-005 iCLK  in  1  sole clock; all logic on rising edge.
REQ-006 iRST  in  1  reset, synchronous, active-high.
REQ-007 iGo  in  1  start a frame read; sampled only in IDLE.
REQ-008 oSDRAM_addr  out  23  read word address.
REQ-009 oSDRAM_read  out  1  read request; address valid while high.
REQ-010 iSDRAM_wait  in  1  SDRAM stall; request accepted on a cycle with oSDRAM_read=1 and iSDRAM_wait=0.
REQ-011 iSDRAM_data  in  16  returned read word.
REQ-012 iSDRAM_valid  in  1  iSDRAM_data valid this cycle; returns arrive in request order.
REQ-013 iVGA_req  in  1  VGA side pops one pixel this cycle.
REQ-014 oVGA_data  out  16  head-of-FIFO pixel (show-ahead).
REQ-015 oVGA_valid  out  1  FIFO non-empty.
REQ-016 oBusy  out  1  high in FETCH or DRAIN.
REQ-017 oDone  out  1  one-cycle pulse when the last pixel of a frame is popped.
REQ-018 oUnderflow  out  1  sticky error flag (see Configuration).

Function
REQ-019 FSM states IDLE, FETCH, DRAIN; IDLE->FETCH on iGo=1; x,y counters cleared on entry.
REQ-020 In FETCH, oSDRAM_read=1 iff fifo_count + outstanding < FIFO_DEPTH; outstanding = accepted requests not yet returned.
REQ-021 oSDRAM_addr = BASE_ADDR + y*H_PIXELS + x, computed at 23 bits, wrap modulo 2^23; held stable while iSDRAM_wait=1.
REQ-022 On each accepted request x increments; at x=H_PIXELS-1, x->0 and y increments.
REQ-023 Acceptance at x=H_PIXELS-1, y=V_LINES-1: FETCH->DRAIN, oSDRAM_read low from next cycle.
REQ-024 Each iSDRAM_valid writes iSDRAM_data into the FIFO and decrements outstanding in the same cycle.
REQ-025 Same-cycle acceptance and return: outstanding unchanged; same-cycle return and pop: fifo_count unchanged.
REQ-026 iVGA_req with oVGA_valid=1 pops head; oVGA_data updates to the next entry the following cycle.
REQ-027 iVGA_req with oVGA_valid=0: no pop, no state change except REQ-035.
REQ-028 Pop count reaches H_PIXELS*V_LINES: oDone pulses that cycle, DRAIN->IDLE next cycle.
REQ-029 iGo ignored outside IDLE; iGo=1 in the cycle of DRAIN->IDLE has no effect.
REQ-030 iSDRAM_valid arriving in IDLE is discarded.
REQ-031 Read latency: first oVGA_valid one cycle after first iSDRAM_valid.

Reset
REQ-032 iRST=1 at any clock edge, including mid-frame: state=IDLE, x=y=0, outstanding=0, FIFO emptied, oSDRAM_read=0, oSDRAM_addr=0, oVGA_data=0, oVGA_valid=0, oBusy=0, oDone=0, oUnderflow=0.
REQ-033 Returns arriving after reset that belong to an aborted frame are discarded per REQ-030.

Configuration
REQ-034 Macro SDRAM_IMAGE_READER_UNDERFLOW_EN selects underflow detection.
REQ-035 Defined: oUnderflow set when iVGA_req=1 and oVGA_valid=0 while oBusy=1; cleared only by iRST or iGo acceptance.
REQ-036 Undefined: oUnderflow tied 0, no detection logic.

Verification
REQ-037 H=4,V=2,BASE=0x100, iGo, zero wait, 2-cycle return, VGA pops every cycle -> addresses 0x100..0x107 in order, 8 pixels match, oDone pulses once on 8th pop.
REQ-038 VGA never pops, DEPTH=8 -> exactly 8 reads accepted, oSDRAM_read stays low, oVGA_data shows first word.
REQ-039 iSDRAM_wait=1 for 5 cycles at addr 0x102 -> addr held 0x102, no increment, resumes 0x103 after release.
REQ-040 iRST=1 after 3 accepted requests -> all outputs reset next cycle; one late return ignored; new iGo restarts at BASE_ADDR.
REQ-041 UNDERFLOW_EN defined, iVGA_req=1 with FIFO empty during FETCH -> oUnderflow=1 until next iGo; undefined -> stays 0.
REQ-042 BASE=0x7FFFFE, H=4,V=1 -> addresses 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001.

Source files
------------

// File: rtl/sdram_image_reader_if.sv
// Bus bundle for sdram_image_reader: SDRAM read port, VGA pixel port and frame control/status.
// The master modport is the reader's view; the slave modport is the SDRAM/VGA environment's view.
interface sdram_image_reader_if;
  logic        iGo;
  logic [22:0] oSDRAM_addr;
  logic        oSDRAM_read;
  logic        iSDRAM_wait;
  logic [15:0] iSDRAM_data;
  logic        iSDRAM_valid;
  logic        iVGA_req;
  logic [15:0] oVGA_data;
  logic        oVGA_valid;
  logic        oBusy;
  logic        oDone;
  logic        oUnderflow;

  modport master (
    input  iGo,
    input  iSDRAM_wait,
    input  iSDRAM_data,
    input  iSDRAM_valid,
    input  iVGA_req,
    output oSDRAM_addr,
    output oSDRAM_read,
    output oVGA_data,
    output oVGA_valid,
    output oBusy,
    output oDone,
    output oUnderflow
  );

  modport slave (
    output iGo,
    output iSDRAM_wait,
    output iSDRAM_data,
    output iSDRAM_valid,
    output iVGA_req,
    input  oSDRAM_addr,
    input  oSDRAM_read,
    input  oVGA_data,
    input  oVGA_valid,
    input  oBusy,
    input  oDone,
    input  oUnderflow
  );
endinterface

// File: rtl/sdram_image_reader.sv
// Streams one H_PIXELS x V_LINES frame from SDRAM into a show-ahead pixel FIFO for a VGA consumer.
// Optional sticky underflow detection is enabled by defining SDRAM_IMAGE_READER_UNDERFLOW_EN.
module sdram_image_reader #(
  parameter int          H_PIXELS   = 160,
  parameter int          V_LINES    = 120,
  parameter logic [22:0] BASE_ADDR  = 23'h0,
  parameter int          FIFO_DEPTH = 8
) (
  input logic                  iCLK,
  input logic                  iRST,
  sdram_image_reader_if.master bus
);

  localparam int XW    = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW    = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int TOTAL = H_PIXELS * V_LINES;
  localparam int PW    = $clog2(TOTAL + 1);
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  localparam logic [XW-1:0] X_LAST     = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(V_LINES - 1);
  localparam logic [PW-1:0] POP_LAST   = PW'(TOTAL - 1);
  localparam logic [CW:0]   DEPTH_FULL = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [22:0]     addr_q, addr_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   pop_cnt_q, pop_cnt_d;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [15:0]     mem_d [FIFO_DEPTH];

  logic [CW:0]     occupancy;
  logic            read_en;
  logic            accept;
  logic            ret;
  logic            vga_valid;
  logic            pop;
  logic            last_pop;
  logic            last_req;
  logic            go;

  // Requests are throttled so every in-flight word is guaranteed a FIFO slot on return.
  always_comb begin
    occupancy = {1'b0, count_q} + {1'b0, outstanding_q};
    read_en   = (state_q == FETCH) && (occupancy < DEPTH_FULL);
    accept    = read_en && !bus.iSDRAM_wait;
    ret       = bus.iSDRAM_valid && (state_q != IDLE) && (outstanding_q != '0);
    vga_valid = (count_q != '0);
    pop       = bus.iVGA_req && vga_valid;
    last_pop  = pop && (state_q != IDLE) && (pop_cnt_q == POP_LAST);
    last_req  = accept && (x_q == X_LAST) && (y_q == Y_LAST);
    go        = (state_q == IDLE) && bus.iGo;
  end

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    addr_d        = addr_q;
    outstanding_d = outstanding_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pop_cnt_d     = pop_cnt_q;
    mem_d         = mem_q;

    case (state_q)
      IDLE: begin
        if (go) begin
          state_d   = FETCH;
          x_d       = '0;
          y_d       = '0;
          addr_d    = BASE_ADDR;
          pop_cnt_d = '0;
        end
      end
      FETCH: begin
        if (accept) begin
          // Row-major pixels are contiguous, so the address simply advances by one word.
          addr_d = addr_q + 23'd1;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
          if (last_req) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = DRAIN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (last_pop) begin
      state_d = IDLE;
    end

    case ({accept, ret})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (ret) begin
      mem_d[wr_ptr_q] = bus.iSDRAM_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      pop_cnt_d = pop_cnt_q + PW'(1);
    end

    case ({ret, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      addr_q        <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pop_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      addr_q        <= addr_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pop_cnt_q     <= pop_cnt_d;
    end
  end

  // Storage needs no reset: the output mux hides stale entries whenever the FIFO is empty.
  always_ff @(posedge iCLK) begin
    mem_q <= mem_d;
  end

  assign bus.oSDRAM_read = read_en;
  assign bus.oSDRAM_addr = addr_q;
  assign bus.oVGA_valid  = vga_valid;
  assign bus.oVGA_data   = vga_valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign bus.oBusy       = (state_q != IDLE);
  assign bus.oDone       = last_pop;

`ifdef SDRAM_IMAGE_READER_UNDERFLOW_EN
  logic underflow_q, underflow_d;

  always_comb begin
    underflow_d = underflow_q;
    if (go) begin
      underflow_d = 1'b0;
    end else if (bus.iVGA_req && !vga_valid && (state_q != IDLE)) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
    end
  end

  assign bus.oUnderflow = underflow_q;
`else
  assign bus.oUnderflow = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_image_reader.sv
// Self-checking bench for sdram_image_reader: a frame-level model on DUT A plus literal checks on both DUTs.
// DUT B exercises 23-bit address wrap and FIFO back-pressure with no VGA pops.
module tb_sdram_image_reader;

  localparam int          TOTAL_A = 8;
  localparam int          DEPTH_A = 8;
  localparam logic [22:0] BASE_A  = 23'h100;
`ifdef SDRAM_IMAGE_READER_UNDERFLOW_EN
  localparam logic UF_EXP = 1'b1;
`else
  localparam logic UF_EXP = 1'b0;
`endif

  typedef struct {
    int          due;
    logic [22:0] addr;
  } ret_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_image_reader_if if_a ();
  sdram_image_reader_if if_b ();

  sdram_image_reader #(
    .H_PIXELS  (4),
    .V_LINES   (2),
    .BASE_ADDR (23'h100),
    .FIFO_DEPTH(8)
  ) dut_a (
    .iCLK(clk),
    .iRST(rst),
    .bus (if_a.master)
  );

  sdram_image_reader #(
    .H_PIXELS  (4),
    .V_LINES   (4),
    .BASE_ADDR (23'h7FFFFE),
    .FIFO_DEPTH(8)
  ) dut_b (
    .iCLK(clk),
    .iRST(rst),
    .bus (if_b.master)
  );

  int checks = 0;
  int errors = 0;

  int   m_acc = 0, m_ret = 0, m_pop = 0;
  logic m_active = 1'b0;
  logic m_uf = 1'b0;
  int   done_pulses = 0;
  int   m_cyc = 0;
  ret_t rq[$];
  logic [22:0] a_log[$];
  logic [22:0] b_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] pix(input logic [22:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // Frame model: the k-th accepted read must address BASE+k, the k-th popped pixel is pix(BASE+k).
  always @(negedge clk) begin
    logic        exp_read, exp_valid, popv, exp_done;
    logic [22:0] ea;
    exp_read  = m_active && (m_acc < TOTAL_A) && ((m_acc - m_pop) < DEPTH_A);
    exp_valid = (m_ret - m_pop) > 0;
    popv      = if_a.iVGA_req && exp_valid;
    exp_done  = m_active && popv && (m_pop == TOTAL_A - 1);
    check("read", 32'(if_a.oSDRAM_read), 32'(exp_read));
    check("vga_valid", 32'(if_a.oVGA_valid), 32'(exp_valid));
    check("busy", 32'(if_a.oBusy), 32'(m_active));
    check("done", 32'(if_a.oDone), 32'(exp_done));
    check("underflow", 32'(if_a.oUnderflow), 32'(m_uf));
    if (exp_read) begin
      ea = BASE_A + 23'(m_acc);
      check("addr", 32'(if_a.oSDRAM_addr), 32'(ea));
    end
    if (exp_valid) begin
      ea = BASE_A + 23'(m_pop);
      check("pixel", 32'(if_a.oVGA_data), 32'(pix(ea)));
    end
    if (if_a.oDone === 1'b1) done_pulses++;

    if (rst) begin
      m_active = 1'b0;
      m_acc = 0; m_ret = 0; m_pop = 0;
      m_uf = 1'b0;
    end else if (!m_active) begin
      if (if_a.iGo) begin
        m_active = 1'b1;
        m_acc = 0; m_ret = 0; m_pop = 0;
        m_uf = 1'b0;
      end
    end else begin
`ifdef SDRAM_IMAGE_READER_UNDERFLOW_EN
      if (if_a.iVGA_req && !exp_valid) m_uf = 1'b1;
`endif
      if (exp_read && !if_a.iSDRAM_wait) m_acc++;
      if (if_a.iSDRAM_valid) m_ret++;
      if (popv) m_pop++;
      if (exp_done) m_active = 1'b0;
    end
  end

  // SDRAM responders: A returns two cycles after acceptance, B one cycle after.
  initial begin
    logic        b_pend;
    logic [22:0] b_paddr;
    b_pend = 1'b0;
    b_paddr = '0;
    if_a.iSDRAM_valid = 1'b0;
    if_a.iSDRAM_data  = '0;
    if_b.iSDRAM_valid = 1'b0;
    if_b.iSDRAM_data  = '0;
    forever begin
      @(negedge clk);
      if (if_a.oSDRAM_read && !if_a.iSDRAM_wait) begin
        rq.push_back('{m_cyc + 2, if_a.oSDRAM_addr});
        a_log.push_back(if_a.oSDRAM_addr);
      end
      b_pend = if_b.oSDRAM_read && !if_b.iSDRAM_wait;
      if (b_pend) begin
        b_paddr = if_b.oSDRAM_addr;
        b_log.push_back(if_b.oSDRAM_addr);
      end
      @(posedge clk);
      m_cyc++;
      #1;
      if (rq.size() > 0 && rq[0].due <= m_cyc) begin
        if_a.iSDRAM_valid = 1'b1;
        if_a.iSDRAM_data  = pix(rq[0].addr);
        void'(rq.pop_front());
      end else begin
        if_a.iSDRAM_valid = 1'b0;
        if_a.iSDRAM_data  = '0;
      end
      if_b.iSDRAM_valid = b_pend;
      if_b.iSDRAM_data  = b_pend ? pix(b_paddr) : 16'h0000;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle_a(input int max);
    int n = 0;
    while (m_active && n < max) begin
      step();
      n++;
    end
    check("frame_completes", 32'(if_a.oBusy), 32'd0);
  endtask

  task automatic check_reset_a();
    check("rst_read", 32'(if_a.oSDRAM_read), 32'd0);
    check("rst_addr", 32'(if_a.oSDRAM_addr), 32'd0);
    check("rst_vga_valid", 32'(if_a.oVGA_valid), 32'd0);
    check("rst_vga_data", 32'(if_a.oVGA_data), 32'd0);
    check("rst_busy", 32'(if_a.oBusy), 32'd0);
    check("rst_done", 32'(if_a.oDone), 32'd0);
    check("rst_underflow", 32'(if_a.oUnderflow), 32'd0);
  endtask

  task automatic apply_stimulus();
    logic [22:0] exp_t1[8];
    logic [22:0] exp_b[4];
    int base;
    int d0;
    exp_t1 = '{23'h100, 23'h101, 23'h102, 23'h103, 23'h104, 23'h105, 23'h106, 23'h107};
    exp_b  = '{23'h7FFFFE, 23'h7FFFFF, 23'h000000, 23'h000001};

    if_a.iGo = 1'b0; if_a.iSDRAM_wait = 1'b0; if_a.iVGA_req = 1'b0;
    if_b.iGo = 1'b0; if_b.iSDRAM_wait = 1'b0; if_b.iVGA_req = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check_reset_a();

    // DUT B: no pops, wrap-around addresses, exactly one FIFO's worth of reads.
    step();
    if_b.iGo = 1'b1;
    step();
    if_b.iGo = 1'b0;
    repeat (20) step();
    @(negedge clk);
    check("b_accepted", 32'(b_log.size()), 32'd8);
    for (int i = 0; i < 4; i++) check($sformatf("b_addr%0d", i), 32'(b_log[i]), 32'(exp_b[i]));
    check("b_read_low", 32'(if_b.oSDRAM_read), 32'd0);
    check("b_vga_valid", 32'(if_b.oVGA_valid), 32'd1);
    check("b_first_word", 32'(if_b.oVGA_data), 32'h0000A5A4);
    check("b_busy", 32'(if_b.oBusy), 32'd1);
    check("b_done", 32'(if_b.oDone), 32'd0);
    check("b_underflow", 32'(if_b.oUnderflow), 32'd0);

    // Full frame on A with zero wait and a pop request every cycle.
    base = a_log.size();
    d0 = done_pulses;
    step();
    if_a.iGo = 1'b1;
    if_a.iVGA_req = 1'b1;
    step();
    if_a.iGo = 1'b0;
    wait_idle_a(60);
    step();
    check("t1_done_pulses", 32'(done_pulses - d0), 32'd1);
    check("t1_accepted", 32'(a_log.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("t1_addr%0d", i), 32'(a_log[base + i]), 32'(exp_t1[i]));
    @(negedge clk);
    check("t1_underflow_sticky", 32'(if_a.oUnderflow), 32'(UF_EXP));

    // Stall at 0x102 for five cycles.
    d0 = done_pulses;
    step();
    if_a.iGo = 1'b1;
    step();
    if_a.iGo = 1'b0;
    step();
    step();
    if_a.iSDRAM_wait = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_addr_held", 32'(if_a.oSDRAM_addr), 32'h102);
      step();
    end
    if_a.iSDRAM_wait = 1'b0;
    @(negedge clk);
    check("release_addr", 32'(if_a.oSDRAM_addr), 32'h102);
    step();
    @(negedge clk);
    check("resume_addr", 32'(if_a.oSDRAM_addr), 32'h103);
    wait_idle_a(60);
    check("t3_done_pulses", 32'(done_pulses - d0), 32'd1);

    // Reset mid-frame after three accepted requests, with late returns still in flight.
    if_a.iVGA_req = 1'b0;
    step();
    if_a.iGo = 1'b1;
    step();
    if_a.iGo = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_reset_a();
    step();
    @(negedge clk);
    check("late_return_dropped", 32'(if_a.oVGA_valid), 32'd0);
    check("late_return_idle", 32'(if_a.oBusy), 32'd0);
    repeat (4) step();
    base = a_log.size();
    d0 = done_pulses;
    if_a.iGo = 1'b1;
    if_a.iVGA_req = 1'b1;
    step();
    if_a.iGo = 1'b0;
    wait_idle_a(60);
    check("restart_base", 32'(a_log[base]), 32'h100);
    check("t4_done_pulses", 32'(done_pulses - d0), 32'd1);
    if_a.iVGA_req = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    apply_stimulus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
